// File: rtl/tx_frame_arbiter.sv
// Frame-level round-robin arbiter sharing one MAC transmit port between two
// receive paths (byte FIFO + length FIFO each), with malformed-frame discard.
module tx_frame_arbiter #(
    parameter int MAX_LEN    = 1514,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             len0_empty,
    output logic             len0_rd,
    input  logic [15:0]      len0_data,
    input  logic             dat0_empty,
    output logic             dat0_rd,
    input  logic [7:0]       dat0_data,
    input  logic             len1_empty,
    output logic             len1_rd,
    input  logic [15:0]      len1_data,
    input  logic             dat1_empty,
    output logic             dat1_rd,
    input  logic [7:0]       dat1_data,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_RD  = 3'd1;
    localparam logic [2:0] S_LEN_CHK = 3'd2;
    localparam logic [2:0] S_XFER    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    localparam int          GAP_W     = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    logic [2:0]       state_q, state_d;
    logic             sel_q, sel_d;
    logic             ptr_q, ptr_d;
    logic [1:0]       grant_q, grant_d;
    logic [15:0]      rem_q, rem_d;
    logic             inflight_q, inflight_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [15:0] len_s;
    logic [7:0]  dat_s;
    logic        dat_empty_s;
    logic        req0, req1;
    logic        hs, out_free, rem_nz;
    logic        xfer_rd, drain_rd, len_rd_s;
    logic        gap_done, drop_inc;

    assign len_s       = sel_q ? len1_data : len0_data;
    assign dat_s       = sel_q ? dat1_data : dat0_data;
    assign dat_empty_s = sel_q ? dat1_empty : dat0_empty;
    assign req0        = ~len0_empty;
    assign req1        = ~len1_empty;

    assign hs       = tx_valid_q & tx_ready;
    assign out_free = ~tx_valid_q | hs;
    assign rem_nz   = (rem_q != 16'd0);
    assign len_rd_s = (state_q == S_LEN_RD);
    assign gap_done = (GAP_CYCLES <= 1) || (gap_q == GAP_W'(GAP_CYCLES - 1));

    // One read in flight, and only when the output register will be free
    // by the time the byte returns.
    assign xfer_rd  = (state_q == S_XFER) & rem_nz & ~dat_empty_s
                    & ~inflight_q & out_free;
    assign drain_rd = (state_q == S_DRAIN) & rem_nz & ~dat_empty_s;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        rem_d      = rem_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        gap_d      = gap_q;
        drop_d     = drop_q;
        drop_inc   = 1'b0;
        inflight_d = xfer_rd;

        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    sel_d   = ptr_q ? req1 : ~req0;
                    grant_d = sel_d ? 2'b10 : 2'b01;
                    state_d = S_LEN_RD;
                end
            end
            S_LEN_RD: begin
                state_d = S_LEN_CHK;
            end
            S_LEN_CHK: begin
                rem_d = len_s;
                if (len_s == 16'd0) begin
                    drop_inc = 1'b1;
                    grant_d  = 2'b00;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end else if (len_s > MAX_LEN_W) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (hs && tx_last_q) begin
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                    ptr_d      = ~sel_q;
                    grant_d    = 2'b00;
                    gap_d      = '0;
                    state_d    = S_GAP;
                end else begin
                    if (hs) begin
                        tx_valid_d = 1'b0;
                    end
                    if (inflight_q && rem_nz) begin
                        tx_data_d  = dat_s;
                        tx_valid_d = 1'b1;
                        tx_last_d  = (rem_q == 16'd1);
                        rem_d      = rem_q - 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!rem_nz) begin
                    drop_inc = 1'b1;
                    ptr_d    = ~sel_q;
                    grant_d  = 2'b00;
                    gap_d    = '0;
                    state_d  = S_GAP;
                end else if (drain_rd) begin
                    rem_d = rem_q - 16'd1;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            ptr_q      <= 1'b0;
            grant_q    <= 2'b00;
            rem_q      <= 16'd0;
            inflight_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            drop_q     <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            drop_q     <= drop_d;
            gap_q      <= gap_d;
        end
    end

    // Outputs are forced low for the whole reset cycle so a mid-frame
    // reset never pops a FIFO or presents a stale byte.
    assign len0_rd  = rst_n & len_rd_s & ~sel_q;
    assign len1_rd  = rst_n & len_rd_s & sel_q;
    assign dat0_rd  = rst_n & (xfer_rd | drain_rd) & ~sel_q;
    assign dat1_rd  = rst_n & (xfer_rd | drain_rd) & sel_q;
    assign tx_data  = tx_data_q & {8{rst_n}};
    assign tx_valid = tx_valid_q & rst_n;
    assign tx_last  = tx_last_q & rst_n;
    assign grant    = grant_q & {2{rst_n}};
    assign busy     = rst_n & (state_q != S_IDLE);
    assign drop_cnt = drop_q & {CNT_W{rst_n}};

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: FIFO models feed directed frames,
// a negedge monitor pops expected bytes on every MAC handshake.
module tb_tx_frame_arbiter;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        len0_empty = 1'b1;
    logic        len1_empty = 1'b1;
    logic        dat0_empty = 1'b1;
    logic        dat1_empty = 1'b1;
    logic        len0_rd, len1_rd, dat0_rd, dat1_rd;
    logic [15:0] len0_data = '0;
    logic [15:0] len1_data = '0;
    logic [7:0]  dat0_data = '0;
    logic [7:0]  dat1_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_last;
    logic        tx_ready = 1'b1;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] drop_cnt;

    logic [15:0] lq0[$];
    logic [15:0] lq1[$];
    logic [7:0]  dq0[$];
    logic [7:0]  dq1[$];
    logic [10:0] sb[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   rd1_cnt = 0;
    int   last_hs_cyc = 0;
    int   busy_fall_cyc = 0;
    logic prev_busy = 1'b0;
    logic hold_v = 1'b0;
    logic [8:0] hold = '0;

    tx_frame_arbiter #(.MAX_LEN(1514), .GAP_CYCLES(GAP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .len0_empty(len0_empty), .len0_rd(len0_rd), .len0_data(len0_data),
        .dat0_empty(dat0_empty), .dat0_rd(dat0_rd), .dat0_data(dat0_data),
        .len1_empty(len1_empty), .len1_rd(len1_rd), .len1_data(len1_data),
        .dat1_empty(dat1_empty), .dat1_rd(dat1_rd), .dat1_data(dat1_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .grant(grant), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // FIFO models: registered read data, one clock after the strobe.
    always @(posedge clk) begin
        if (len0_rd) begin
            tests++;
            if (lq0.size() == 0) begin
                fails++;
                $display("FAIL len0_rd_empty: got rd=1 required rd=0");
            end else len0_data <= lq0.pop_front();
        end
        if (len1_rd) begin
            tests++;
            if (lq1.size() == 0) begin
                fails++;
                $display("FAIL len1_rd_empty: got rd=1 required rd=0");
            end else len1_data <= lq1.pop_front();
        end
        if (dat0_rd) begin
            tests++;
            if (dq0.size() == 0) begin
                fails++;
                $display("FAIL dat0_rd_empty: got rd=1 required rd=0");
            end else dat0_data <= dq0.pop_front();
        end
        if (dat1_rd) begin
            rd1_cnt++;
            tests++;
            if (dq1.size() == 0) begin
                fails++;
                $display("FAIL dat1_rd_empty: got rd=1 required rd=0");
            end else dat1_data <= dq1.pop_front();
        end
    end

    always @(negedge clk) begin
        len0_empty = (lq0.size() == 0);
        len1_empty = (lq1.size() == 0);
        dat0_empty = (dq0.size() == 0);
        dat1_empty = (dq1.size() == 0);
    end

    // Monitor: scoreboard pop on handshake, hold-stability, busy edge.
    always @(negedge clk) begin
        logic [10:0] e;
        cyc++;
        if (rst_n && hold_v) begin
            tests++;
            if ({tx_valid, tx_data, tx_last} !== {1'b1, hold}) begin
                fails++;
                $display("FAIL hold_stable: got v=%0b d=%0h l=%0b required v=1 d=%0h l=%0b",
                         tx_valid, tx_data, tx_last, hold[8:1], hold[0]);
            end
        end
        hold_v = rst_n && tx_valid && !tx_ready;
        hold   = {tx_data, tx_last};
        if (rst_n && tx_valid && tx_ready) begin
            tests++;
            hs_cnt++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL tx_unexpected: got d=%0h l=%0b g=%0b required no byte",
                         tx_data, tx_last, grant);
            end else begin
                e = sb.pop_front();
                if ({tx_data, tx_last, grant} !== e) begin
                    fails++;
                    $display("FAIL tx_byte: got d=%0h l=%0b g=%0b required d=%0h l=%0b g=%0b",
                             tx_data, tx_last, grant, e[10:3], e[2], e[1:0]);
                end
            end
            if (tx_last) last_hs_cyc = cyc;
        end
        if (rst_n && prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic void push_len(input int p, input int n);
        if (p == 0) lq0.push_back(16'(n));
        else lq1.push_back(16'(n));
    endfunction

    function automatic void push_dat(input int p, input logic [7:0] b);
        if (p == 0) dq0.push_back(b);
        else dq1.push_back(b);
    endfunction

    function automatic void frame(input int p, input int n,
                                  input logic [7:0] b0, input logic [7:0] step);
        logic [7:0] b = b0;
        push_len(p, n);
        for (int i = 0; i < n; i++) begin
            push_dat(p, b);
            b = b + step;
        end
    endfunction

    function automatic void exp_frame(input int p, input int n,
                                      input logic [7:0] b0, input logic [7:0] step);
        logic [7:0] b = b0;
        for (int i = 0; i < n; i++) begin
            sb.push_back({b, (i == n - 1), (p == 0) ? 2'b01 : 2'b10});
            b = b + step;
        end
    endfunction

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!(sb.size() == 0 && !busy && lq0.size() == 0 && lq1.size() == 0)
               && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, (n >= max) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx"}, {tx_data, tx_valid, tx_last, grant, busy}, 32'd0);
        chk({tag, "_rd"}, {len0_rd, len1_rd, dat0_rd, dat1_rd}, 32'd0);
        chk({tag, "_drop"}, drop_cnt, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_zero("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        lq0.delete();
        lq1.delete();
        dq0.delete();
        dq1.delete();
        @(negedge clk);
        chk_zero("after_reset");
    endtask

    initial begin
        int k;
        int n;
        int bad;
        int base;
        logic [3:0] pat = 4'b1001;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_state", {busy, grant}, 32'd0);

        // single frame on path 0
        @(posedge clk);
        #1 frame(0, 3, 8'hAA, 8'h11);
        exp_frame(0, 3, 8'hAA, 8'h11);
        wait_done("t1", 200);
        @(negedge clk);
        chk("t1_busy_fall", 32'(busy_fall_cyc - last_hs_cyc), 32'(GAP + 1));
        chk("t1_drop", drop_cnt, 32'd0);

        // alternating grants, pointer starts at path 0
        do_reset();
        @(posedge clk);
        #1;
        frame(0, 4, 8'h10, 8'h01);
        frame(0, 4, 8'h20, 8'h01);
        frame(1, 4, 8'h30, 8'h01);
        frame(1, 4, 8'h40, 8'h01);
        exp_frame(0, 4, 8'h10, 8'h01);
        exp_frame(1, 4, 8'h30, 8'h01);
        exp_frame(0, 4, 8'h20, 8'h01);
        exp_frame(1, 4, 8'h40, 8'h01);
        wait_done("t2", 400);

        // backpressure pattern 1,0,0,1
        base = hs_cnt;
        @(posedge clk);
        #1 frame(0, 5, 8'h50, 8'h01);
        exp_frame(0, 5, 8'h50, 8'h01);
        k = 0;
        for (int i = 0; i < 200 && k < 5; i++) begin
            tx_ready = pat[i % 4];
            @(negedge clk);
            if (tx_valid && tx_ready) k++;
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_done("t3", 200);
        chk("t3_handshakes", 32'(hs_cnt - base), 32'd5);

        // oversize discard, then a good frame, then a zero length
        base = rd1_cnt;
        @(posedge clk);
        #1;
        push_len(1, 2000);
        for (int i = 0; i < 2000; i++) push_dat(1, 8'hEE);
        frame(1, 2, 8'h5A, 8'h4B);
        exp_frame(1, 2, 8'h5A, 8'h4B);
        wait_done("t4", 5000);
        chk("t4_rd_count", 32'(rd1_cnt - base), 32'd2002);
        chk("t4_drop1", drop_cnt, 32'd1);
        @(posedge clk);
        #1 push_len(1, 0);
        wait_done("t4_zero", 100);
        chk("t4_drop2", drop_cnt, 32'd2);
        chk("t4_zero_rd", 32'(rd1_cnt - base), 32'd2002);

        // data FIFO underrun mid-frame
        @(posedge clk);
        #1;
        push_len(0, 6);
        push_dat(0, 8'h61);
        push_dat(0, 8'h62);
        exp_frame(0, 6, 8'h61, 8'h01);
        k = 0;
        for (int i = 0; i < 200 && k < 2; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) k++;
        end
        chk("t5_first_two", 32'(k), 32'd2);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid) bad++;
        end
        chk("t5_stall_valid", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_dat(0, 8'(8'h63 + i));
        wait_done("t5", 200);

        // reset while byte 3 of 8 is pending
        @(posedge clk);
        #1 frame(0, 8, 8'h71, 8'h01);
        exp_frame(0, 8, 8'h71, 8'h01);
        k = 0;
        for (int i = 0; i < 200 && k < 2; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) k++;
        end
        @(posedge clk);
        #1 tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_byte3_pending", {tx_valid, tx_data}, {23'd0, 1'b1, 8'h73});
        do_reset();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (len0_rd | len1_rd | dat0_rd | dat1_rd) bad++;
        end
        chk("t6_no_rd", 32'(bad), 32'd0);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        frame(1, 1, 8'h81, 8'h00);
        frame(0, 1, 8'h91, 8'h00);
        exp_frame(0, 1, 8'h91, 8'h00);
        exp_frame(1, 1, 8'h81, 8'h00);
        wait_done("t6", 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
